// File: rtl/ldo_pkg.sv
// Shared types for the LDO loop sequencer: state and band encodings plus
// helpers that map between the two.
package ldo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COARSE = 3'd1,
        MEDIUM = 3'd2,
        FINE   = 3'd3,
        STEADY = 3'd4
    } ldo_state_t;

    // Bands are ordered so that a larger value means a finer loop
    typedef enum logic [1:0] {
        BAND_COARSE = 2'd0,
        BAND_MEDIUM = 2'd1,
        BAND_FINE   = 2'd2
    } ldo_band_t;

    // STEADY is the dithered form of the fine band
    function automatic ldo_band_t state_band(input ldo_state_t s);
        case (s)
            COARSE:  return BAND_COARSE;
            MEDIUM:  return BAND_MEDIUM;
            default: return BAND_FINE;
        endcase
    endfunction

    function automatic ldo_state_t band_state(input ldo_band_t b);
        case (b)
            BAND_COARSE: return COARSE;
            BAND_MEDIUM: return MEDIUM;
            default:     return FINE;
        endcase
    endfunction

endpackage

// File: rtl/ldo_band_classify.sv
// Combinational band selection from the load-current code with saturating
// hysteresis on coarser moves; hysteresis is built only with LDO_SEQ_HYST_EN.
module ldo_band_classify
    import ldo_pkg::*;
#(
    parameter int CUR_W = 8,
    parameter int HYST  = 2
) (
    input  ldo_band_t          band,
    input  logic [CUR_W-1:0]   load_current,
    input  logic [CUR_W-1:0]   thr_coarse,
    input  logic [CUR_W-1:0]   thr_medium,
    output ldo_band_t          band_next
);

`ifdef LDO_SEQ_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // Without hysteresis the lowered thresholds collapse onto the raw ones
    localparam int HYST_EFF = 0 * HYST;
`endif

    localparam logic [CUR_W-1:0] MARGIN = CUR_W'(HYST_EFF);

    function automatic ldo_band_t classify(input logic [CUR_W-1:0] cur,
                                           input logic [CUR_W-1:0] tc,
                                           input logic [CUR_W-1:0] tm);
        if (cur < tc)
            return BAND_COARSE;
        else if (cur < tm)
            return BAND_MEDIUM;
        return BAND_FINE;
    endfunction

    logic [CUR_W-1:0] thr_coarse_dn;
    logic [CUR_W-1:0] thr_medium_dn;
    ldo_band_t        band_up;
    ldo_band_t        band_dn;

    // Finer moves use the raw thresholds, coarser moves the lowered ones
    always_comb begin
        thr_coarse_dn = (thr_coarse > MARGIN) ? thr_coarse - MARGIN : '0;
        thr_medium_dn = (thr_medium > MARGIN) ? thr_medium - MARGIN : '0;
        band_up       = classify(load_current, thr_coarse, thr_medium);
        band_dn       = classify(load_current, thr_coarse_dn, thr_medium_dn);
        band_next     = band;
        if (band_up > band)
            band_next = band_up;
        else if (band_dn < band)
            band_next = band_dn;
    end

endmodule

// File: rtl/ldo_loop_sequencer.sv
// Mode sequencer for the digital LDO: picks coarse/medium/fine/steady loop
// from the load-current band, with FINE settle timer and relock counter.
module ldo_loop_sequencer
    import ldo_pkg::*;
#(
    parameter int CUR_W      = 8,
    parameter int SETTLE_CYC = 16,
    parameter int HYST       = 2,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_change,
    input  logic             dither_enable,
    input  logic [CUR_W-1:0] load_current,
    input  logic [CUR_W-1:0] thr_coarse,
    input  logic [CUR_W-1:0] thr_medium,
    output logic             coarse_loop,
    output logic             medium_loop,
    output logic             fine_loop,
    output logic             steady_state,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] relock_cnt
);

    localparam int               SET_W       = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    ldo_state_t       state_q;
    ldo_state_t       state_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic             relock_hit;
    ldo_band_t        band_cur;
    ldo_band_t        band_next;

    assign band_cur = state_band(state_q);
    assign state    = state_q;

    ldo_band_classify #(
        .CUR_W (CUR_W),
        .HYST  (HYST)
    ) u_classify (
        .band         (band_cur),
        .load_current (load_current),
        .thr_coarse   (thr_coarse),
        .thr_medium   (thr_medium),
        .band_next    (band_next)
    );

    // Priority: disable, relock event, band move, then settle/dither
    always_comb begin
        state_d    = state_q;
        settle_d   = '0;
        relock_hit = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = COARSE;
        end else if (load_change) begin
            state_d    = COARSE;
            relock_hit = 1'b1;
        end else if (band_next != band_cur) begin
            state_d = band_state(band_next);
        end else begin
            case (state_q)
                FINE: begin
                    if (settle_q == SETTLE_LAST) begin
                        if (dither_enable)
                            state_d = STEADY;
                        else
                            settle_d = settle_q;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                STEADY: begin
                    if (!dither_enable)
                        state_d = FINE;
                end
                COARSE, MEDIUM: state_d = state_q;
                default:        state_d = IDLE;
            endcase
        end
    end

    // Loop selects are registered from the next state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            relock_cnt   <= '0;
            coarse_loop  <= 1'b0;
            medium_loop  <= 1'b0;
            fine_loop    <= 1'b0;
            steady_state <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            coarse_loop  <= (state_d == COARSE);
            medium_loop  <= (state_d == MEDIUM);
            fine_loop    <= (state_d == FINE);
            steady_state <= (state_d == STEADY);
            if (relock_hit && (relock_cnt != '1))
                relock_cnt <= relock_cnt + 1'b1;
        end
    end

endmodule

// File: doc/ldo_loop_sequencer.md
# ldo_loop_sequencer

Parametrised mode sequencer for the digital LDO. It selects which regulation loop drives the pass-device array: coarse, medium, fine, or dithered steady state. Selection comes from a multi-bit load-current code compared against runtime-programmable thresholds, with optional hysteresis, a settle timer before steady-state entry, and a saturating relock counter. It sits between the load-current sensor/ADC and the coarse/medium/fine loop controllers.

## Interface
- `CUR_W`, 8: width of load-current code and thresholds
- `SETTLE_CYC`, 16: consecutive FINE cycles required before STEADY is allowed; ≥1
- `HYST`, 2: hysteresis margin in LSBs for downward (coarser) band moves
- `CNT_W`, 6: relock counter width
- `clk` in 1: clock
- `rst` in 1: reset; asynchronous, active-high
- `en` in 1: sequencer enable
- `load_change` in 1: load-step event; sampled every cycle
- `dither_enable` in 1: permission to enter or hold STEADY
- `load_current` in CUR_W: unsigned load-current code
- `thr_coarse` in CUR_W: coarse/medium boundary
- `thr_medium` in CUR_W: medium/fine boundary
- `coarse_loop`, `medium_loop`, `fine_loop`, `steady_state` out 1 each: loop selects; at most one high
- `state` out 3: current state encoding
- `relock_cnt` out CNT_W: accepted load_change events, saturating

## Operation
- States: IDLE, COARSE, MEDIUM, FINE, STEADY. Outputs decode directly from the state register. IDLE drives all four selects low.
- Priority per cycle, highest first: `rst`, then `!en`, then `load_change`, then band move, then settle/dither.
- `!en`: any state goes to IDLE. From IDLE with `en`=1, go to COARSE.
- `load_change`=1 in any non-IDLE state: go to COARSE, clear the settle counter, increment `relock_cnt` (saturates at all-ones). Ignored in IDLE.
- Band classification applies to COARSE/MEDIUM/FINE/STEADY and is checked in this order:
  - coarse if `load_current < thr_coarse`
  - else medium if `load_current < thr_medium`
  - else fine
- Moves to a finer band use the raw thresholds. Moves to a coarser band use `thr − HYST`, saturating at 0. Band jumps of two levels are allowed.
- STEADY counts as the fine band. If its band changes, go to the classified state.
- If `thr_coarse ≥ thr_medium`, MEDIUM is unreachable. This is legal.
- FINE settle:
  - Counter width is clog2(SETTLE_CYC+1). It clears on every FINE entry and increments each cycle the state stays FINE.
  - When the counter equals SETTLE_CYC−1 and `dither_enable`=1, go to STEADY.
  - If `dither_enable`=0 at that point, hold the counter and stay in FINE.
- STEADY with `dither_enable`=0: go to FINE. The settle counter clears.

## Timing
- Reset values: `state`=IDLE (0), all selects 0, `relock_cnt`=0, settle counter 0. Reset takes effect immediately on assertion.
- Latency: an input sampled at edge N changes the state and outputs after edge N. All selects are registered decodes and are glitch-free.
- Minimum FINE dwell before STEADY: SETTLE_CYC cycles.
- Simultaneous `load_change` and band move: COARSE wins. `!en` together with `load_change`: IDLE wins and `relock_cnt` does not increment.
- Threshold changes take effect on the next classification edge. No synchronisation is required; inputs are synchronous to `clk`.

## Configuration
- Macro `LDO_SEQ_HYST_EN`.
  - Defined: downward moves use `thr − HYST` as specified above.
  - Undefined: `HYST` is ignored and all moves use the raw thresholds.

## Structure
- Package `ldo_pkg` holds:
  - `ldo_state_t` enum (3-bit): IDLE=0, COARSE=1, MEDIUM=2, FINE=3, STEADY=4
  - `ldo_band_t` enum: BAND_COARSE, BAND_MEDIUM, BAND_FINE
- Sub-module `ldo_band_classify`: combinational. It takes the current band, `load_current` and both thresholds, and returns the next band with saturating hysteresis. The `LDO_SEQ_HYST_EN` guard lives inside this sub-module.

## Test plan
All scenarios use CUR_W=8, SETTLE_CYC=4, HYST=2, `thr_coarse`=40, `thr_medium`=100, hysteresis enabled.
- Reset mid-STEADY: assert `rst` → all selects 0, `state`=0 and `relock_cnt`=0 immediately, without waiting for a clock edge.
- Acquisition: `en`=1, `load_current`=120, `dither_enable`=1 → COARSE, then FINE, then FINE for 4 cycles total, then STEADY.
- Hysteresis: in MEDIUM at 60, drop to 39 → stay MEDIUM. Drop to 37 → COARSE next cycle. Rise to 40 → MEDIUM.
- Dither hold: reach FINE with `dither_enable`=0 for 10 cycles → stays FINE. Raise `dither_enable` → STEADY next cycle. Drop it → FINE.
- Simultaneous events: in STEADY, pulse `load_change` with `load_current`=20 → COARSE and `relock_cnt`+1. With `en`=0 in the same cycle → IDLE and no increment.
- Relock saturation: with CNT_W=2, apply 5 `load_change` pulses while active → `relock_cnt`=3.
